rs_encoder: RTL

Systematic RS(255,251) encoder over GF(2^8), the transmit-side counterpart of the RS(255,251) decoder chain (syndrome/euclid/chien/forney). It accepts a 251-symbol message stream using the same val/sop/eop byte framing the decoder consumes. It passes the message through unchanged and appends 4 parity symbols, producing a 255-symbol codeword. Parity is computed by a 4-stage GF LFSR dividing by g(x) = (x+α^0)(x+α^1)(x+α^2)(x+α^3).

---
 rtl/rs_encoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rs_encoder.sv
// Systematic RS(255,251) encoder over GF(2^8): passes the message through and appends
// four parity symbols from an LFSR dividing by g(x) = (x+a^0)(x+a^1)(x+a^2)(x+a^3).
//
// state  | meaning
// IDLE   | waiting for an accepted sop; non-sop symbols are dropped
// DATA   | message symbols pass to dout while the LFSR accumulates parity
// PARITY | r3..r0 shifted out on four cycles, input stalled

module rs_encoder #(
    parameter int MSG_LEN = 251,
    parameter int NPAR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_val,
    input  logic       din_sop,
    input  logic       din_eop,
    input  logic [7:0] din,
    output logic       din_rdy,
    output logic       dout_val,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic [7:0] dout,
    output logic       len_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic [7:0] LEN      = 8'(MSG_LEN);
    localparam logic [1:0] LAST_PAR = 2'(NPAR - 1);

    // Multiply by a constant in GF(2^8) mod 0x11D; with k fixed this folds to XOR gates.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return acc;
    endfunction

    state_t     state, state_n;
    logic [7:0] r3, r2, r1, r0;
    logic [7:0] r3_n, r2_n, r1_n, r0_n;
    logic [7:0] cnt, cnt_n, cnt_inc;
    logic [1:0] pcnt, pcnt_n;
    logic [7:0] dout_n;
    logic       val_n, sop_n, eop_n, lerr_n;
    logic       acc, at_max;
    logic [7:0] fb;
    logic [7:0] shift_in3, shift_in2, shift_in1;

    assign din_rdy = (state != PARITY);
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        r3_n    = r3;
        r2_n    = r2;
        r1_n    = r1;
        r0_n    = r0;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        dout_n  = dout;
        val_n   = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        lerr_n  = 1'b0;

        acc     = din_val && din_rdy;
        // A sop symbol starts a fresh division, so the old remainder is ignored.
        fb        = din ^ (din_sop ? 8'h00 : r3);
        shift_in3 = din_sop ? 8'h00 : r2;
        shift_in2 = din_sop ? 8'h00 : r1;
        shift_in1 = din_sop ? 8'h00 : r0;
        cnt_inc   = din_sop ? 8'd1 : cnt + 8'd1;
        at_max    = (cnt_inc == LEN);

        case (state)
            IDLE, DATA: begin
                if (acc && (din_sop || state == DATA)) begin
                    r3_n    = shift_in3 ^ gf_mul_const(fb, 8'h0F);
                    r2_n    = shift_in2 ^ gf_mul_const(fb, 8'h36);
                    r1_n    = shift_in1 ^ gf_mul_const(fb, 8'h78);
                    r0_n    = gf_mul_const(fb, 8'h40);
                    cnt_n   = cnt_inc;
                    dout_n  = din;
                    val_n   = 1'b1;
                    sop_n   = din_sop;
                    state_n = DATA;
                    if (state == DATA && din_sop) lerr_n = 1'b1;
                    if (din_eop || at_max) begin
                        state_n = PARITY;
                        pcnt_n  = 2'd0;
                        // Error when eop came early, or the count filled without an eop.
                        if (din_eop != at_max) lerr_n = 1'b1;
                    end
                end
            end
            PARITY: begin
                dout_n = r3;
                val_n  = 1'b1;
                eop_n  = (pcnt == LAST_PAR);
                r3_n   = r2;
                r2_n   = r1;
                r1_n   = r0;
                r0_n   = 8'h00;
                pcnt_n = pcnt + 2'd1;
                if (pcnt == LAST_PAR) begin
                    state_n = IDLE;
                    cnt_n   = 8'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            r3       <= 8'h00;
            r2       <= 8'h00;
            r1       <= 8'h00;
            r0       <= 8'h00;
            cnt      <= 8'd0;
            pcnt     <= 2'd0;
            dout     <= 8'h00;
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            state    <= state_n;
            r3       <= r3_n;
            r2       <= r2_n;
            r1       <= r1_n;
            r0       <= r0_n;
            cnt      <= cnt_n;
            pcnt     <= pcnt_n;
            dout     <= dout_n;
            dout_val <= val_n;
            dout_sop <= sop_n;
            dout_eop <= eop_n;
            len_err  <= lerr_n;
        end
    end

endmodule
